fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares a single `sync_fifo` write port among `NUM_REQ` producers. Each producer presents beats with a valid/ready handshake. The arbiter grants one producer at a time for a burst: up to `HOLD_MAX` beats, or until `req_last`. It drives the FIFO's `wr_en`/`wr_data` and honours the FIFO's `full` flag. It sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arb_pkg.sv | 25 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb_pkg
// Description : Shared types and constants for the FIFO write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_WIDTH = 16;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = 16'hFFFF;

  // Wide enough for HOLD_MAX up to 15.
  localparam int CNT_WIDTH = 4;

  function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == STAT_MAX) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational search for the first set request bit at or
//               after a pointer, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IDW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NUM_REQ valid/ready producers. Optional per-producer beat
//               statistics are built when FIFO_WR_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int HOLD_MAX   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           fifo_wr_en,
  output logic [DATA_WIDTH-1:0]          fifo_wr_data,
  input  logic                           fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]     gnt_id,
  output logic                           gnt_active,
  input  logic                           stat_clr,
  output logic [NUM_REQ*STAT_WIDTH-1:0]  stat_beats
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] c_last_beat = CNT_WIDTH'(HOLD_MAX - 1);
  localparam logic [IDW-1:0]       c_last_id   = IDW'(NUM_REQ - 1);

  arb_state_e           r_state, w_state_nxt;
  logic [IDW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [IDW-1:0]       r_gnt_id, w_gnt_id_nxt;
  logic [CNT_WIDTH-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [IDW-1:0]       w_pick_idx;
  logic                 w_pick_any;
  logic                 w_accept;
  logic                 w_release;
  logic [DATA_WIDTH-1:0] w_gnt_data;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  assign w_gnt_data = req_data[int'(r_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
  assign w_accept   = (r_state == BURST) && req_valid[r_gnt_id] && !fifo_full;
  assign w_release  = w_accept && (req_last[r_gnt_id] || (r_beat_cnt == c_last_beat));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_rr_ptr   <= '0;
      r_gnt_id   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_gnt_id_nxt   = r_gnt_id;
    w_beat_cnt_nxt = r_beat_cnt;
    req_ready      = '0;
    unique case (r_state)
      ARB: begin
        if (w_pick_any) begin
          w_gnt_id_nxt = w_pick_idx;
          w_state_nxt  = BURST;
        end
      end
      BURST: begin
        req_ready[r_gnt_id] = !fifo_full;
        if (w_release) begin
          w_state_nxt    = ARB;
          w_rr_ptr_nxt   = (r_gnt_id == c_last_id) ? '0 : r_gnt_id + 1'b1;
          w_beat_cnt_nxt = '0;
        end else if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  assign gnt_id       = r_gnt_id;
  assign gnt_active   = (r_state == BURST);
  assign fifo_wr_en   = w_accept;
  assign fifo_wr_data = gnt_active ? w_gnt_data : '0;

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [STAT_WIDTH-1:0] r_cnt;
    // A clear in the same cycle as an accept takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (stat_clr) begin
        r_cnt <= '0;
      end else if (w_accept && (r_gnt_id == IDW'(g))) begin
        r_cnt <= stat_inc(r_cnt);
      end
    end
    assign stat_beats[g*STAT_WIDTH +: STAT_WIDTH] = r_cnt;
  end
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr;
  assign stat_beats        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter (transaction model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int HM = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_full = 1'b0;
  logic [1:0]      gnt_id;
  logic            gnt_active;
  logic            stat_clr = 1'b0;
  logic [N*16-1:0] stat_beats;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full), .gnt_id(gnt_id),
    .gnt_active(gnt_active), .stat_clr(stat_clr), .stat_beats(stat_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t q[$];
  int    owner, ptr, beats;
  int    stat[N];
  int    checks = 0, errors = 0;
  int    grant_log[$], gbeats_log[$], wr_log[$];
  logic  full_v = 1'b0, clr_v = 1'b0;
  logic [N-1:0] en_v = '1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pin(input string nm, input int got[$], input int exp[$]);
    check({nm, "_len"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++) check(nm, got[k], exp[k]);
  endtask

  function automatic int head(input int id);
    foreach (q[k]) if (q[k].id == id) return k;
    return -1;
  endfunction

  function automatic logic [N*16-1:0] exp_stat();
    logic [N*16-1:0] v;
    v = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) v[i*16 +: 16] = 16'(stat[i]);
`endif
    return v;
  endfunction

  task automatic push(input int id, input logic [7:0] d, input logic l);
    beat_t b;
    b.id = id; b.d = d; b.l = l;
    q.push_back(b);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      int h;
      h = head(i);
      req_valid[i]          = (h >= 0) && en_v[i];
      req_data[i*DW +: DW]  = (h >= 0) ? q[h].d : 8'h00;
      req_last[i]           = (h >= 0) ? q[h].l : 1'b0;
    end
    fifo_full = full_v;
    stat_clr  = clr_v;
  endtask

  // One clock: drive at negedge, compare settled outputs, then advance the model.
  task automatic cycle();
    logic [N-1:0] e_rdy;
    logic         acc, lst;
    logic [7:0]   e_d;
    int           nxt, h, o;
    @(negedge clk);
    drive();
    #1;
    acc = 1'b0; e_rdy = '0; e_d = 8'h00;
    if (owner >= 0) begin
      e_rdy = full_v ? '0 : (N'(1) << owner);
      acc   = req_valid[owner] && !full_v;
      e_d   = req_data[owner*DW +: DW];
    end
    check("gnt_active", gnt_active, owner >= 0);
    if (owner >= 0) check("gnt_id", gnt_id, owner);
    check("req_ready", req_ready, e_rdy);
    check("fifo_wr_en", fifo_wr_en, acc);
    check("fifo_wr_data", fifo_wr_data, e_d);
    check("stat_beats", stat_beats, exp_stat());
    if (fifo_wr_en) wr_log.push_back(int'(fifo_wr_data));
    o = owner;
    if (clr_v) begin
      for (int i = 0; i < N; i++) stat[i] = 0;
    end else if (acc) begin
      stat[o] = (stat[o] >= 65535) ? 65535 : stat[o] + 1;
    end
    if (owner < 0) begin
      nxt = -1;
      for (int k = 0; k < N; k++)
        if (nxt < 0 && req_valid[(ptr + k) % N]) nxt = (ptr + k) % N;
      if (nxt >= 0) begin
        owner = nxt; beats = 0;
        grant_log.push_back(owner);
        gbeats_log.push_back(0);
      end
    end else if (acc) begin
      h = head(owner);
      lst = q[h].l;
      q.delete(h);
      beats++;
      gbeats_log[gbeats_log.size()-1] += 1;
      if (lst || beats == HM) begin
        ptr = (owner + 1) % N;
        owner = -1;
      end
    end
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((q.size() != 0 || owner >= 0) && c < maxc) begin
      cycle();
      c++;
      if (q.size() == 0 && owner >= 0 && !(req_valid != 0)) c = maxc + 1;
    end
    if (c == maxc) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", q.size());
    end
  endtask

  task automatic model_reset();
    owner = -1; ptr = 0; beats = 0;
    for (int i = 0; i < N; i++) stat[i] = 0;
    q.delete();
    grant_log.delete(); gbeats_log.delete(); wr_log.delete();
    full_v = 1'b0; clr_v = 1'b0; en_v = '1;
    drive();
  endtask

  // Asynchronous reset placed between clock edges; outputs must clear at once.
  task automatic do_reset(input string nm);
    #1 rst_n = 1'b0;
    #1;
    check({nm, "_wr_en"}, fifo_wr_en, 1'b0);
    check({nm, "_active"}, gnt_active, 1'b0);
    check({nm, "_ready"}, req_ready, '0);
    check({nm, "_gnt_id"}, gnt_id, '0);
    check({nm, "_wr_data"}, fifo_wr_data, '0);
    check({nm, "_stat"}, stat_beats, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[$];
    model_reset();
    repeat (2) @(negedge clk);
    do_reset("rst0");

    // Producer 0 three-beat burst, then rr_ptr=1 makes producer 1 win next.
    push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
    drain(20);
    e = '{32'h11, 32'h22, 32'h33}; pin("t1_wr", wr_log, e);
    push(0, 8'h44, 1); push(1, 8'h55, 1);
    drain(20);
    e = '{0, 1, 0}; pin("t1_gnt", grant_log, e);

    // All producers with single-beat bursts.
    do_reset("rst1");
    for (int i = 0; i < N; i++) push(i, 8'(8'h20 + i), 1);
    push(0, 8'h30, 1);
    drain(40);
    e = '{0, 1, 2, 3, 0}; pin("t2_gnt", grant_log, e);
    e = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h30}; pin("t2_wr", wr_log, e);

    // Long burst from producer 2 is cut at HOLD_MAX and re-queued round-robin.
    do_reset("rst2");
    push(0, 8'h01, 0); push(0, 8'h02, 1);
    for (int k = 0; k < 10; k++) push(2, 8'(8'hB0 + k), 0);
    push(3, 8'h03, 0); push(3, 8'h04, 1);
    drain(60);
    repeat (2) cycle();
    e = '{0, 2, 3, 2, 2}; pin("t3_gnt", grant_log, e);
    e = '{2, 4, 2, 4, 2}; pin("t3_beats", gbeats_log, e);

    // FIFO full for three cycles mid-burst, plus a valid stall.
    do_reset("rst3");
    push(1, 8'hA1, 0); push(1, 8'hA2, 0); push(1, 8'hA3, 1);
    for (int c = 0; c < 10; c++) begin
      full_v = (c >= 2 && c <= 4);
      en_v[1] = (c != 6);
      cycle();
    end
    e = '{32'hA1, 32'hA2, 32'hA3}; pin("t4_wr", wr_log, e);

    // Reset during beat 2 of a burst; arbitration restarts from pointer 0.
    do_reset("rst4");
    push(0, 8'h50, 1);
    drain(20);
    for (int k = 0; k < 4; k++) push(2, 8'(8'hC0 + k), 0);
    repeat (3) cycle();
    check("t5_pre_wr_en", fifo_wr_en, 1'b1);
    do_reset("t5_mid");
    push(3, 8'h70, 1); push(0, 8'h60, 1);
    drain(20);
    e = '{0, 3}; pin("t5_gnt", grant_log, e);
    e = '{32'h60, 32'h70}; pin("t5_wr", wr_log, e);

    // Statistics: five beats from producer 1, clear, clear racing an accept.
    do_reset("rst5");
    for (int k = 0; k < 5; k++) push(1, 8'(8'h81 + k), k == 4);
    drain(30);
`ifdef FIFO_WR_ARB_STATS_EN
    check("t6_stat1", stat_beats[31:16], 16'd5);
`else
    check("t6_stat1", stat_beats[31:16], 16'd0);
`endif
    clr_v = 1'b1; cycle(); clr_v = 1'b0; cycle();
    check("t6_clr", stat_beats, '0);
    push(1, 8'h91, 0); push(1, 8'h92, 1);
    cycle(); cycle();
    clr_v = 1'b1; cycle(); clr_v = 1'b0;
    drain(10);
    cycle();
`ifdef FIFO_WR_ARB_STATS_EN
    check("t6_clr_race", stat_beats[31:16], 16'd0);
`else
    check("t6_clr_race", stat_beats[31:16], 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
